// File: rtl/alu_nibble_sequencer.sv
// Drives a 16-bit operation through one external 4-bit 74181-style ALU, one nibble per
// cycle (LSB first), rippling the active-low carry and assembling result, carry and zero.
module alu_nibble_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [3:0]  select,
    input  logic        mode_control,
    input  logic        carry_in,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [3:0]  alu_select,
    output logic        alu_mode_control,
    output logic        alu_carry_in,
    input  logic [3:0]  alu_function_output,
    input  logic        alu_carry_out,
    input  logic        alu_comparator_output,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry_out,
    output logic        zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  idx;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic        zero_acc;
    logic [1:0]  idx_next;
    logic        zero_next;

    function automatic logic [3:0] get_nibble(input logic [15:0] word, input logic [1:0] n);
        logic [3:0] nib;
        case (n)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            default: nib = word[15:12];
        endcase
        return nib;
    endfunction

    function automatic logic [15:0] put_nibble(input logic [15:0] word, input logic [1:0] n,
                                               input logic [3:0] nib);
        logic [15:0] w;
        w = word;
        case (n)
            2'd0:    w[3:0]   = nib;
            2'd1:    w[7:4]   = nib;
            2'd2:    w[11:8]  = nib;
            default: w[15:12] = nib;
        endcase
        return w;
    endfunction

    assign idx_next  = idx + 2'd1;
    assign zero_next = zero_acc & alu_comparator_output;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // The alu_* registers are the nibble drive itself; they are only reloaded while
    // another nibble remains, so they hold their last values once the run ends.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            idx              <= 2'd0;
            a_reg            <= 16'h0000;
            b_reg            <= 16'h0000;
            zero_acc         <= 1'b0;
            result           <= 16'h0000;
            carry_out        <= 1'b1;
            zero             <= 1'b0;
            alu_a            <= 4'h0;
            alu_b            <= 4'h0;
            alu_select       <= 4'h0;
            alu_mode_control <= 1'b0;
            alu_carry_in     <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    result   <= put_nibble(result, idx, alu_function_output);
                    zero_acc <= zero_next;
                    idx      <= idx_next;
                    if (idx == 2'd3) begin
                        state     <= DONE;
                        carry_out <= alu_carry_out;
                        zero      <= zero_next;
                    end else begin
                        alu_a        <= get_nibble(a_reg, idx_next);
                        alu_b        <= get_nibble(b_reg, idx_next);
                        alu_carry_in <= alu_carry_out;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, which gives gap-free chaining
                    if (start) begin
                        state            <= RUN;
                        idx              <= 2'd0;
                        zero_acc         <= 1'b1;
                        a_reg            <= operand_a;
                        b_reg            <= operand_b;
                        alu_a            <= operand_a[3:0];
                        alu_b            <= operand_b[3:0];
                        alu_select       <= select;
                        alu_mode_control <= mode_control;
                        alu_carry_in     <= carry_in;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 74181-style ALU attached.
module tb_alu_nibble_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  select;
    logic        mode_control;
    logic        carry_in;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_select;
    logic        alu_mode_control;
    logic        alu_carry_in;
    logic [3:0]  alu_function_output;
    logic        alu_carry_out;
    logic        alu_comparator_output;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        zero;

    int total = 0;
    int bad   = 0;

    alu_nibble_sequencer dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .start                 (start),
        .operand_a             (operand_a),
        .operand_b             (operand_b),
        .select                (select),
        .mode_control          (mode_control),
        .carry_in              (carry_in),
        .alu_a                 (alu_a),
        .alu_b                 (alu_b),
        .alu_select            (alu_select),
        .alu_mode_control      (alu_mode_control),
        .alu_carry_in          (alu_carry_in),
        .alu_function_output   (alu_function_output),
        .alu_carry_out         (alu_carry_out),
        .alu_comparator_output (alu_comparator_output),
        .busy                  (busy),
        .done                  (done),
        .result                (result),
        .carry_out             (carry_out),
        .zero                  (zero)
    );

    always #5 clock = ~clock;

    // ALU model, active-high data, active-low carries: S=1001/M=0 is A plus B plus carry,
    // S=0110/M=1 is A xor B with carry out forced high.
    logic [4:0] sum;
    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, ~alu_carry_in};
        alu_function_output = sum[3:0];
        alu_carry_out       = ~sum[4];
        if (alu_mode_control) begin
            alu_carry_out = 1'b1;
            case (alu_select)
                4'b0110: alu_function_output = alu_a ^ alu_b;
                4'b1011: alu_function_output = alu_a & alu_b;
                4'b1110: alu_function_output = alu_a | alu_b;
                default: alu_function_output = ~alu_a;
            endcase
        end
        alu_comparator_output = (alu_function_output == 4'h0);
    end

    // Drives one start pulse: start is high across exactly one rising edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                            input logic m, input logic cin);
        @(negedge clock);
        operand_a    = a;
        operand_b    = b;
        select       = s;
        mode_control = m;
        carry_in     = cin;
        start        = 1'b1;
        @(negedge clock);
        start        = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0; operand_a = 16'hFFFF; operand_b = 16'hFFFF;
        select = 4'hF; mode_control = 1'b1; carry_in = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result: got %h want 0000", result); end
        total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL reset_carry_out: got %b want 1", carry_out); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b want 0", zero); end
        total++; if ({alu_a, alu_b, alu_select, alu_mode_control, alu_carry_in} !== 14'b1)
            begin bad++; $display("FAIL reset_alu_drive: got %h %h %h %b %b want 0 0 0 0 1",
                                  alu_a, alu_b, alu_select, alu_mode_control, alu_carry_in); end
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_start_busy: got %b want 0", busy); end
    endtask

    task automatic test_add(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic [15:0] exp_res,
                            input logic exp_co, input logic exp_zero);
        start_op(a, b, 4'b1001, 1'b0, cin);
        for (int c = 0; c < 4; c++) begin
            total++; if (busy !== 1'b1 || done !== 1'b0)
                begin bad++; $display("FAIL %s_run%0d: busy=%b done=%b want busy=1 done=0", name, c, busy, done); end
            if (c < 3) @(negedge clock);
        end
        @(negedge clock);
        total++; if (done !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL %s_done: done=%b busy=%b want done=1 busy=0", name, done, busy); end
        total++; if (result !== exp_res) begin bad++; $display("FAIL %s_result: got %h want %h", name, result, exp_res); end
        total++; if (carry_out !== exp_co) begin bad++; $display("FAIL %s_carry_out: got %b want %b", name, carry_out, exp_co); end
        total++; if (zero !== exp_zero) begin bad++; $display("FAIL %s_zero: got %b want %b", name, zero, exp_zero); end
        @(negedge clock);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse: got %b want 0", name, done); end
        total++; if (result !== exp_res) begin bad++; $display("FAIL %s_result_hold: got %h want %h", name, result, exp_res); end
    endtask

    task automatic test_logic_xor;
        logic [3:0] exp_a [4];
        exp_a[0] = 4'h5; exp_a[1] = 4'hA; exp_a[2] = 4'h5; exp_a[3] = 4'hA;
        start_op(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            total++; if (alu_a !== exp_a[c]) begin bad++; $display("FAIL xor_alu_a%0d: got %h want %h", c, alu_a, exp_a[c]); end
            total++; if (alu_select !== 4'b0110 || alu_mode_control !== 1'b1)
                begin bad++; $display("FAIL xor_alu_ctl%0d: got %b/%b want 0110/1", c, alu_select, alu_mode_control); end
            @(negedge clock);
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL xor_done: got %b want 1", done); end
        total++; if (result !== 16'h5A5A) begin bad++; $display("FAIL xor_result: got %h want 5a5a", result); end
        total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL xor_carry_out: got %b want 1", carry_out); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL xor_zero: got %b want 0", zero); end
        @(negedge clock);
        total++; if (alu_a !== 4'hA) begin bad++; $display("FAIL xor_alu_a_hold: got %h want a", alu_a); end
    endtask

    task automatic test_start_in_run;
        int dones;
        dones = 0;
        start_op(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        if (done) dones++;
        @(negedge clock);
        if (done) dones++;
        operand_a = 16'h1234; operand_b = 16'h1111; carry_in = 1'b0;
        start = 1'b1;
        @(negedge clock);
        if (done) dones++;
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (done) dones++;
        end
        total++; if (dones != 1) begin bad++; $display("FAIL run_start_dones: got %0d want 1", dones); end
        total++; if (result !== 16'h1000) begin bad++; $display("FAIL run_start_result: got %h want 1000", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL run_start_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int dones;
        dones = 0;
        @(negedge clock);
        operand_a = 16'h1234; operand_b = 16'h1111; select = 4'b1001;
        mode_control = 1'b0; carry_in = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (done) dones++;
            total++; if (done !== (c % 5 == 0) || busy !== (c % 5 != 0))
                begin bad++; $display("FAIL b2b_cycle%0d: done=%b busy=%b want done=%b", c, done, busy, (c % 5 == 0)); end
        end
        start = 1'b0;
        total++; if (dones != 4) begin bad++; $display("FAIL b2b_dones: got %0d want 4", dones); end
        total++; if (result !== 16'h2346) begin bad++; $display("FAIL b2b_result: got %h want 2346", result); end
        @(negedge clock);
        total++; if (busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_reset_mid;
        int dones;
        dones = 0;
        start_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        total++; if (busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL midrst_state: busy=%b done=%b want 0 0", busy, done); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL midrst_result: got %h want 0000", result); end
        total++; if (carry_out !== 1'b1 || zero !== 1'b0)
            begin bad++; $display("FAIL midrst_flags: co=%b zero=%b want 1 0", carry_out, zero); end
        total++; if (alu_carry_in !== 1'b1 || alu_a !== 4'h0)
            begin bad++; $display("FAIL midrst_alu: cin=%b a=%h want 1 0", alu_carry_in, alu_a); end
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (done) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
    endtask

    initial begin
        test_reset;
        test_add("ripple", 16'h0FFF, 16'h0001, 1'b1, 16'h1000, 1'b1, 1'b0);
        test_add("overflow", 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b1);
        test_add("carry_in", 16'h1234, 16'h1111, 1'b0, 16'h2346, 1'b1, 1'b0);
        test_logic_xor;
        test_start_in_run;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
